debug_cmd_sequencer: RTL

- Command controller between the UART byte link and the MIPS pipeline inside the debug unit.
- Decodes host command bytes and loads programs into instruction memory 32-bit word by word.
- Gates the CPU clock enable for continuous or single-step execution.
- After each run or step, streams the register file back to the host over the UART TX handshake.

---
 rtl/debug_pkg.sv | 16 +
 rtl/debug_cmd_sequencer_if.sv | 29 ++
 rtl/debug_word_tx.sv | 43 ++++
 rtl/debug_cmd_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: command codes, FSM state encoding and register address width for the debug sequencer
package debug_pkg;
    localparam int REG_ADDR = 5;
    localparam logic [7:0] CMD_LOAD = 8'd1;
    localparam logic [7:0] CMD_RUN  = 8'd4;
    localparam logic [7:0] CMD_STEP = 8'd6;
    localparam logic [7:0] CMD_EXIT = 8'd7;
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD_CNT   = 3'd1;
    localparam logic [2:0] S_LOAD_BYTE  = 3'd2;
    localparam logic [2:0] S_LOAD_WRITE = 3'd3;
    localparam logic [2:0] S_RUN        = 3'd4;
    localparam logic [2:0] S_STEP_WAIT  = 3'd5;
    localparam logic [2:0] S_STEP_EXEC  = 3'd6;
    localparam logic [2:0] S_DUMP       = 3'd7;
endpackage

// File: rtl/debug_cmd_sequencer_if.sv
// debug_cmd_sequencer_if: UART, instruction memory, register file and CPU control signals of the debug unit
interface debug_cmd_sequencer_if import debug_pkg::*; #(
    parameter int BYTE    = 8,
    parameter int ADDR    = 7,
    parameter int NB_DATA = 32
);
    logic [BYTE-1:0]     i_rx_data;
    logic                i_rx_done;
    logic                i_tx_done;
    logic                i_halt;
    logic [NB_DATA-1:0]  i_reg_data;
    logic [NB_DATA-1:0]  i_pc;
    logic [BYTE-1:0]     o_tx_data;
    logic                o_tx_start;
    logic                o_cpu_enable;
    logic                o_imem_we;
    logic [ADDR-1:0]     o_imem_addr;
    logic [NB_DATA-1:0]  o_imem_data;
    logic [REG_ADDR-1:0] o_reg_addr;
    logic                o_busy;
    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_halt, i_reg_data, i_pc,
        output o_tx_data, o_tx_start, o_cpu_enable, o_imem_we, o_imem_addr, o_imem_data, o_reg_addr, o_busy
    );
    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_halt, i_reg_data, i_pc,
        input  o_tx_data, o_tx_start, o_cpu_enable, o_imem_we, o_imem_addr, o_imem_data, o_reg_addr, o_busy
    );
endinterface

// File: rtl/debug_word_tx.sv
// debug_word_tx: sends one word MSB-first as bytes over the tx_start/tx_done handshake; done is combinational on the last tx_done
module debug_word_tx #(
    parameter int BYTE    = 8,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NB_DATA-1:0] word,
    input  logic               tx_done,
    output logic [BYTE-1:0]    tx_data,
    output logic               tx_start,
    output logic               done
);
    logic               active;
    logic [1:0]         cnt;
    logic [NB_DATA-1:0] sh;
    assign tx_data = sh[NB_DATA-1 -: BYTE];
    assign done    = active && tx_done && cnt == 2'(NB_DATA/BYTE-1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= '0;
            sh       <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                cnt      <= '0;
                sh       <= word;
                tx_start <= 1'b1;
            end else if (active && tx_done) begin
                if (done) active <= 1'b0;
                else begin
                    cnt      <= cnt + 1'b1;
                    sh       <= sh << BYTE;
                    tx_start <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: host command decoder, program loader, run/step gate and register dump for the MIPS debug unit.
// Define DEBUG_PC_DUMP_EN to prefix every dump with the PC latched on dump entry.
module debug_cmd_sequencer import debug_pkg::*; #(
    parameter int BYTE    = 8,
    parameter int ADDR    = 7,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 32
) (
    input logic i_clock,
    input logic i_reset,
    debug_cmd_sequencer_if.slave bus
);
    logic [2:0]          state;
    logic [BYTE-1:0]     n_words;
    logic [1:0]          bcnt;
    logic [ADDR-1:0]     addr;
    logic [NB_DATA-1:0]  word;
    logic [REG_ADDR-1:0] idx;
    logic                inflight, from_run, wt_start, wt_done, pc_busy, rx, last;
    logic [NB_DATA-1:0]  wt_word;
    logic [BYTE-1:0]     cmd;
    assign rx   = bus.i_rx_done;
    assign cmd  = bus.i_rx_data;
    assign last = idx == REG_ADDR'(NB_REG-1);
    assign wt_start = state == S_DUMP && !inflight;
`ifdef DEBUG_PC_DUMP_EN
    logic               pc_phase;
    logic [NB_DATA-1:0] pc_q;
    assign pc_busy = pc_phase;
    assign wt_word = pc_phase ? pc_q : bus.i_reg_data;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pc_phase <= 1'b0;
            pc_q     <= '0;
        end else if (state != S_DUMP) begin
            pc_phase <= 1'b1;
            pc_q     <= bus.i_pc;
        end else if (wt_done) pc_phase <= 1'b0;
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.i_pc;
    assign pc_busy   = 1'b0;
    assign wt_word   = bus.i_reg_data;
`endif
    assign bus.o_cpu_enable = (state == S_RUN && !bus.i_halt) || state == S_STEP_EXEC;
    assign bus.o_imem_we    = state == S_LOAD_WRITE;
    assign bus.o_imem_addr  = addr;
    assign bus.o_imem_data  = word;
    assign bus.o_reg_addr   = idx;
    assign bus.o_busy       = state != S_IDLE && state != S_STEP_WAIT;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= S_IDLE;
            n_words  <= '0;
            bcnt     <= '0;
            addr     <= '0;
            word     <= '0;
            idx      <= '0;
            inflight <= 1'b0;
            from_run <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (rx) state <= cmd == CMD_LOAD ? S_LOAD_CNT : cmd == CMD_RUN ? S_RUN :
                                         cmd == CMD_STEP ? S_STEP_WAIT : S_IDLE;
                S_LOAD_CNT: if (rx) begin
                    n_words <= cmd;
                    addr    <= '0;
                    bcnt    <= '0;
                    state   <= cmd == '0 ? S_IDLE : S_LOAD_BYTE;
                end
                S_LOAD_BYTE: if (rx) begin
                    word <= {word[NB_DATA-BYTE-1:0], cmd};
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 2'(NB_DATA/BYTE-1)) state <= S_LOAD_WRITE;
                end
                S_LOAD_WRITE: begin
                    addr    <= addr + 1'b1;
                    n_words <= n_words - 1'b1;
                    state   <= n_words == BYTE'(1) ? S_IDLE : S_LOAD_BYTE;
                end
                S_RUN: if (bus.i_halt) begin
                    from_run <= 1'b1;
                    state    <= S_DUMP;
                end
                S_STEP_WAIT: if (rx) begin
                    from_run <= 1'b0;
                    state    <= cmd == CMD_STEP ? (bus.i_halt ? S_DUMP : S_STEP_EXEC) :
                                cmd == CMD_EXIT ? S_IDLE : S_STEP_WAIT;
                end
                S_STEP_EXEC: begin
                    from_run <= 1'b0;
                    state    <= S_DUMP;
                end
                S_DUMP: begin
                    if (wt_start) inflight <= 1'b1;
                    if (wt_done) begin
                        inflight <= 1'b0;
                        if (!pc_busy) begin
                            idx <= last ? '0 : idx + 1'b1;
                            if (last) state <= (from_run || bus.i_halt) ? S_IDLE : S_STEP_WAIT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    debug_word_tx #(.BYTE(BYTE), .NB_DATA(NB_DATA)) u_word_tx (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .start    (wt_start),
        .word     (wt_word),
        .tx_done  (bus.i_tx_done),
        .tx_data  (bus.o_tx_data),
        .tx_start (bus.o_tx_start),
        .done     (wt_done)
    );
endmodule
